// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_fifo
// Brief    : Single-clock parameterised FIFO with level flags, status pulses
//            and a clearable high-water mark. Define PARAM_FIFO_FWFT_EN for
//            first-word-fall-through output; the default is a registered read.
// Revision : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_LVL  = FIFO_DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          hwm_clr,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almostfull,
  output logic                          almostempty,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [$clog2(FIFO_DEPTH):0]   hwm
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  generate
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (AEMPTY_LVL < 1) || (AEMPTY_LVL >= AFULL_LVL) ||
        (AFULL_LVL >= FIFO_DEPTH)) begin : g_bad_params
      $fatal(1, "param_sync_fifo: illegal FIFO_DEPTH/AFULL_LVL/AEMPTY_LVL combination");
    end
  endgenerate

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         hwm_q, hwm_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_accept, rd_accept;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CW'(AFULL_LVL));
  assign almostempty = (count_q <= CW'(AEMPTY_LVL));

  always_comb begin
    wr_accept = wr_en && !full;
    rd_accept = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Clear reloads from the post-edge occupancy, not zero.
    if (hwm_clr)                hwm_d = count_d;
    else if (count_d > hwm_q)   hwm_d = count_d;
    else                        hwm_d = hwm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hwm_q       <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hwm_q       <= hwm_d;
      wr_ack_q    <= wr_accept;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_valid = !empty;
`else
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) data_out_q <= mem_q[rd_ptr_q];
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign count     = count_q;
  assign hwm       = hwm_q;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_sync_fifo
// Brief    : Self-checking bench for param_sync_fifo (16x8, AF=6, AE=2) using
//            a vector table, directed corner sequences and a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;

  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en, hwm_clr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd_valid, full, empty, almostfull, almostempty;
  logic        wr_ack, overflow, underflow;
  logic [3:0]  count, hwm;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] q[$];
  int          m_hwm;
  logic [15:0] m_dout;
  logic        m_rvalid, m_ack, m_ovf, m_udf;

  param_sync_fifo #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(DEPTH), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .hwm_clr(hwm_clr), .data_out(data_out),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .count(count), .hwm(hwm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd;
    logic [15:0] din;
    int          ecount, ehwm;
    logic [7:0]  eflags;   // {full,empty,afull,aempty,ack,ovf,udf,valid}
    logic [15:0] edout;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lvl_flags(input int n);
    return {n == DEPTH, n == 0, n >= AFL, n <= AEL};
  endfunction

  task automatic model_reset();
    q.delete();
    m_hwm = 0; m_dout = '0; m_rvalid = 0; m_ack = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic compare_model();
    int          n;
    logic        ev;
    logic [15:0] ed;
    n = q.size();
`ifdef PARAM_FIFO_FWFT_EN
    ev = (n != 0);
    ed = (n != 0) ? q[0] : 16'h0;
`else
    ev = m_rvalid;
    ed = m_dout;
`endif
    chk("model_count", 32'(count), 32'(n));
    chk("model_flags", {24'h0, full, empty, almostfull, almostempty, wr_ack, overflow, underflow, rd_valid},
        {24'h0, lvl_flags(n), m_ack, m_ovf, m_udf, ev});
    chk("model_hwm", 32'(hwm), 32'(m_hwm));
    chk("model_dout", 32'(data_out), 32'(ed));
  endtask

  // One clock cycle: drive, advance the model on the edge, compare after it.
  task automatic step(input logic wr, input logic rd, input logic [15:0] din, input logic clr);
    int  n;
    bit  f, e, wacc, racc;
    wr_en = wr; rd_en = rd; data_in = din; hwm_clr = clr;
    @(posedge clk);
    n = q.size();
    f = (n == DEPTH);
    e = (n == 0);
    wacc = wr && !f;
    racc = rd && !e;
    m_ack = wacc; m_ovf = wr && f; m_udf = rd && e; m_rvalid = racc;
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(din);
    n = q.size();
    m_hwm = clr ? n : ((n > m_hwm) ? n : m_hwm);
    #1;
    compare_model();
    wr_en = 1'b0; rd_en = 1'b0; hwm_clr = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_hwm", 32'(hwm), 0);
    chk("rst_flags", {28'h0, full, empty, almostfull, almostempty}, 32'b0101);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic fill_table();
    for (int i = 0; i < 18; i++) begin
      int n;
      tbl[i].wr = (i < 9);
      tbl[i].rd = (i >= 9);
      tbl[i].din = (i < 9) ? 16'(i + 1) : 16'h0;
      if (i < 8)       n = i + 1;
      else if (i == 8) n = 8;
      else if (i < 17) n = 8 - (i - 8);
      else             n = 0;
      tbl[i].ecount = n;
      tbl[i].ehwm   = (i < 8) ? i + 1 : 8;
`ifdef PARAM_FIFO_FWFT_EN
      tbl[i].edout = (n != 0) ? 16'((i < 9) ? 1 : (i - 8) + 1) : 16'h0;
      tbl[i].eflags = {lvl_flags(n), i < 8, i == 8, i == 17, n != 0};
`else
      tbl[i].edout = (i < 9) ? 16'h0 : ((i < 17) ? 16'(i - 8) : 16'h8);
      tbl[i].eflags = {lvl_flags(n), i < 8, i == 8, i == 17, (i >= 9) && (i < 17)};
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; hwm_clr = 1'b0; data_in = 16'hDEAD;
    model_reset();
    fill_table();
    #12;
    chk("reset_count", 32'(count), 0);
    chk("reset_hwm", 32'(hwm), 0);
    chk("reset_flags", {24'h0, full, empty, almostfull, almostempty, wr_ack, overflow, underflow, rd_valid},
        32'b0101_0000);
    chk("reset_dout", 32'(data_out), 0);
    wr_en = 1'b0; rd_en = 1'b0;
    #1 rst_n = 1'b1;

    // Fill to full, overflow, drain in order, underflow.
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din, 1'b0);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ecount));
      chk($sformatf("tbl%0d_flags", i),
          {24'h0, full, empty, almostfull, almostempty, wr_ack, overflow, underflow, rd_valid},
          {24'h0, tbl[i].eflags});
      chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].edout));
      chk($sformatf("tbl%0d_hwm", i), 32'(hwm), 32'(tbl[i].ehwm));
    end

    // Simultaneous read/write at mid level, at full and at empty.
    mid_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0A00 + 16'(i), 0);
    for (int i = 0; i < 3; i++) step(1, 1, 16'h0B00 + 16'(i), 0);
    chk("both_mid_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0C00 + 16'(i), 0);
    chk("pre_both_full", 32'(full), 1);
    step(1, 1, 16'h0DDD, 0);
    chk("both_full_ovf", 32'(overflow), 1);
    chk("both_full_count", 32'(count), 7);
    while (q.size() > 0) step(0, 1, 16'h0, 0);
    step(1, 1, 16'h0EEE, 0);
    chk("both_empty_udf", 32'(underflow), 1);
    chk("both_empty_count", 32'(count), 1);
    step(0, 1, 16'h0, 0);

    // Stream 20 words through with peak occupancy 7, then clear the mark.
    mid_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 16'h1000 + 16'(i), 0);
    for (int i = 7; i < 20; i++) step(1, 1, 16'h1000 + 16'(i), 0);
    chk("stream_hwm", 32'(hwm), 7);
    for (int i = 0; i < 5; i++) step(0, 1, 16'h0, 0);
    step(0, 0, 16'h0, 1);
    chk("hwm_clr", 32'(hwm), 2);
    step(0, 1, 16'h0, 0);
    step(0, 1, 16'h0, 0);

    // Reset with five entries held, then a fresh word round-trips.
    for (int i = 0; i < 5; i++) step(1, 0, 16'h2000 + 16'(i), 0);
    mid_reset();
    step(1, 0, 16'hBEEF, 0);
`ifdef PARAM_FIFO_FWFT_EN
    chk("beef_fwft", 32'(data_out), 32'h0000BEEF);
`endif
    step(0, 1, 16'h0, 0);
`ifndef PARAM_FIFO_FWFT_EN
    chk("beef_read", 32'(data_out), 32'h0000BEEF);
`endif

    // Randomised traffic alternating fill-biased and drain-biased phases.
    for (int it = 0; it < 600; it++) begin
      int  thr;
      thr = ((it / 40) % 2 == 0) ? 3 : 1;
      step($urandom_range(0, 3) < thr, $urandom_range(0, 3) >= thr,
           16'($urandom), $urandom_range(0, 15) == 0);
      if (it == 300) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entry count; power of two, >= 4.
REQ-003 SHALL have parameter AFULL_LVL, default FIFO_DEPTH-2, almostfull threshold.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2, almostempty threshold; 1 <= AEMPTY_LVL < AFULL_LVL < FIFO_DEPTH.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports wr_en, rd_en  input  1 each  write / read requests.
REQ-008 SHALL have port data_in  input  FIFO_WIDTH  write data.
REQ-009 SHALL have port hwm_clr  input  1  high-water-mark clear.
REQ-010 SHALL have port data_out  output  FIFO_WIDTH  read data.
REQ-011 SHALL have port rd_valid  output  1  data_out qualifier.
REQ-012 SHALL have ports full, empty, almostfull, almostempty  output  1 each  level flags.
REQ-013 SHALL have ports wr_ack, overflow, underflow  output  1 each  registered status pulses.
REQ-014 SHALL have ports count, hwm  output  $clog2(FIFO_DEPTH)+1 each  occupancy / peak occupancy.

Function
REQ-015 SHALL accept a write iff wr_en && !full; SHALL accept a read iff rd_en && !empty.
REQ-016 SHALL, when full with wr_en && rd_en, perform the read only; when empty with both asserted, perform the write only.
REQ-017 SHALL update count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-018 SHALL keep wr_ptr/rd_ptr $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH; data SHALL leave in write order.
REQ-019 SHALL drive full = (count == FIFO_DEPTH), empty = (count == 0), almostfull = (count >= AFULL_LVL), almostempty = (count <= AEMPTY_LVL), combinationally from count.
REQ-020 SHALL pulse wr_ack for one cycle, the cycle after each accepted write.
REQ-021 SHALL pulse overflow the cycle after wr_en is rejected by full; underflow the cycle after rd_en is rejected by empty.
REQ-022 SHALL register hwm <= max(hwm, next count) every cycle; hwm_clr SHALL load hwm with the next count, taking priority.
REQ-023 SHALL leave memory contents, count and pointers unchanged on rejected requests.
REQ-024 SHALL flag illegal parameter combinations with a simulation-time fatal error.

Reset
REQ-025 SHALL, on rst_n low, immediately (no clock edge) clear pointers, count, hwm, data_out, rd_valid, wr_ack, overflow, underflow to 0.
REQ-026 SHALL therefore show empty=1, almostempty=1, full=0, almostfull=0 during reset.
REQ-027 SHALL discard in-flight contents on reset mid-operation; memory array is not reset.
REQ-028 SHALL ignore wr_en/rd_en while rst_n is low; first accepted request is on the first rising edge after deassertion.

Configuration
REQ-029 SHALL support macro PARAM_FIFO_FWFT_EN selecting first-word-fall-through mode.
REQ-030 SHALL, with PARAM_FIFO_FWFT_EN defined, present the head entry on data_out whenever !empty, with rd_valid = !empty; rd_en consumes the shown word.
REQ-031 SHALL, without it, register data_out one cycle after an accepted read, pulse rd_valid in that cycle, and hold data_out otherwise.

Verification (FIFO_WIDTH=16, FIFO_DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=2)
REQ-032 SHALL cover: reset, write 0x0001..0x0008 -> wr_ack each; almostfull at count 6; full at 8; 9th write -> overflow=1 next cycle, count stays 8.
REQ-033 SHALL cover: 8 reads from full -> 0x0001..0x0008 in order (standard: one cycle after rd_en; FWFT: 0x0001 visible before first rd_en); 9th read -> underflow=1, count 0.
REQ-034 SHALL cover: count=4, wr_en && rd_en for 3 cycles -> count stays 4, order preserved; full + both -> read only, overflow=1; empty + both -> write only, underflow=1, count 1.
REQ-035 SHALL cover: stream 20 words with pointer wrap, peak count 7 -> data in order, hwm=7; hwm_clr at count 2 -> hwm=2.
REQ-036 SHALL cover: rst_n low between clock edges at count 5 -> count=0, empty=1, hwm=0 with no clock edge; subsequent write 0xBEEF reads back 0xBEEF.
